// File: rtl/memory_pkg.sv
// Shared constants and types for the MEM stage: funct3 encodings, FSM states, lane patterns.
package memory_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W_BITS = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [BE_W_BITS-1:0] BE_B    = 4'b0001;
  localparam logic [BE_W_BITS-1:0] BE_H    = 4'b0011;
  localparam logic [BE_W_BITS-1:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Request payload presented to data memory for the duration of an access.
  typedef struct packed {
    logic [XLEN-1:0]      addr;
    logic [XLEN-1:0]      wdata;
    logic [BE_W_BITS-1:0] be;
  } mem_req_t;

endpackage

// File: rtl/memory_access_stage_if.sv
// Busywait-style data-memory bus between the MEM stage (master) and data memory (slave).
interface memory_access_stage_if;
  logic [31:0] mem_address;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_byteenable;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  modport master (
    output mem_address, mem_writedata, mem_byteenable, mem_read, mem_write,
    input  mem_readdata, mem_busywait
  );

  modport slave (
    input  mem_address, mem_writedata, mem_byteenable, mem_read, mem_write,
    output mem_readdata, mem_busywait
  );
endinterface

// File: rtl/memory_access_stage_load_store_align.sv
// Lane steering for loads/stores: byte enables, replicated store data,
// extended load data, and detection of illegal (bad size / misaligned / conflicting) accesses.
module load_store_align
  import memory_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  byteenable,
  output logic [31:0] store_shifted,
  output logic [31:0] load_ext,
  output logic        illegal
);

  logic [15:0] lane;
  logic        bad_f3;
  logic        misaligned;

  // Low halfword of the loaded word after shifting the addressed byte down to lane 0.
  assign lane = 16'(load_word >> {addr_lo, 3'b000});

  // Size decode, lane enables, store replication and alignment check.
  always_comb begin
    byteenable    = '0;
    store_shifted = '0;
    misaligned    = 1'b0;
    bad_f3        = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        byteenable    = BE_B << addr_lo;
        store_shifted = {4{store_data[7:0]}};
      end
      2'b01: begin
        byteenable    = BE_H << addr_lo;
        store_shifted = {2{store_data[15:0]}};
        misaligned    = addr_lo[0];
      end
      2'b10: begin
        byteenable    = BE_WORD;
        store_shifted = store_data;
        misaligned    = (addr_lo != 2'b00);
      end
      default: bad_f3 = 1'b1;
    endcase
    // Unsigned variants exist only for loads of byte/half.
    if (funct3[2]) begin
      if (is_store || funct3[1]) bad_f3 = 1'b1;
    end
  end

  // Sign/zero extension of the selected lane.
  always_comb begin
    load_ext = '0;
    case (funct3)
      F3_B:    load_ext = {{24{lane[7]}}, lane[7:0]};
      F3_H:    load_ext = {{16{lane[15]}}, lane[15:0]};
      F3_W:    load_ext = load_word;
      F3_BU:   load_ext = {24'd0, lane[7:0]};
      F3_HU:   load_ext = {16'd0, lane[15:0]};
      default: load_ext = '0;
    endcase
  end

  assign illegal = (is_load & is_store) | ((is_load | is_store) & (bad_f3 | misaligned));

endmodule

// File: rtl/memory_access_stage.sv
// MEM stage: issues busywait-handshaked data-memory accesses, stalls the pipeline
// while one is outstanding, extends load data and flags misaligned/timed-out accesses.
module memory_access_stage
  import memory_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] alu_result,
  input  logic [31:0] data2,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic        memory_read_enable,
  input  logic        memory_write_enable,
  input  logic        regwrite_enable,
  input  logic        mux3_select,
  memory_access_stage_if.master bus,
  output logic [31:0] load_data,
  output logic [31:0] alu_result_out,
  output logic [4:0]  rd_out,
  output logic        regwrite_enable_out,
  output logic        mux3_select_out,
  output logic        stall,
  output logic        misaligned_fault,
  output logic        bus_error
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t         state_q, state_d;
  logic [TO_W-1:0] cnt_q;
  mem_req_t       req_q;
  logic           rd_q, wr_q;
  logic           timed_out_q;
  logic           mis_q, berr_q;
  logic [31:0]    load_data_q;

  logic           op, illegal_c, legal_op;
  logic           launch, done, timeout;
  logic [3:0]     be_c;
  logic [31:0]    wdata_c, load_ext_c;

  load_store_align u_align (
    .addr_lo       (alu_result[1:0]),
    .funct3        (funct3),
    .is_load       (memory_read_enable),
    .is_store      (memory_write_enable),
    .store_data    (data2),
    .load_word     (bus.mem_readdata),
    .byteenable    (be_c),
    .store_shifted (wdata_c),
    .load_ext      (load_ext_c),
    .illegal       (illegal_c)
  );

  assign op       = memory_read_enable | memory_write_enable;
  assign legal_op = op & ~illegal_c;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state, stall and access-event decode.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    launch  = 1'b0;
    done    = 1'b0;
    timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (legal_op) begin
          stall   = 1'b1;
          launch  = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        stall = 1'b1;
        if (!bus.mem_busywait) begin
          done    = 1'b1;
          state_d = RESP;
        end else if (cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          timeout = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request, timeout counter, load capture and fault pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_q       <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      cnt_q       <= '0;
      timed_out_q <= 1'b0;
      mis_q       <= 1'b0;
      berr_q      <= 1'b0;
      load_data_q <= '0;
    end else begin
      mis_q  <= (state_q == IDLE) & op & illegal_c;
      berr_q <= timeout;
      if (launch) begin
        req_q       <= '{addr: {alu_result[31:2], 2'b00}, wdata: wdata_c, be: be_c};
        rd_q        <= memory_read_enable;
        wr_q        <= memory_write_enable;
        cnt_q       <= '0;
        timed_out_q <= 1'b0;
      end else if (done) begin
        rd_q <= 1'b0;
        wr_q <= 1'b0;
        if (rd_q) load_data_q <= load_ext_c;
      end else if (timeout) begin
        rd_q        <= 1'b0;
        wr_q        <= 1'b0;
        timed_out_q <= 1'b1;
      end else if (state_q == ACCESS) begin
        cnt_q <= cnt_q + TO_W'(1);
      end
    end
  end

  assign bus.mem_address    = req_q.addr;
  assign bus.mem_writedata  = req_q.wdata;
  assign bus.mem_byteenable = req_q.be;
  assign bus.mem_read       = rd_q;
  assign bus.mem_write      = wr_q;

  assign load_data        = load_data_q;
  assign misaligned_fault = mis_q;
  assign bus_error        = berr_q;

  assign alu_result_out      = alu_result;
  assign rd_out              = rd;
  assign mux3_select_out     = mux3_select;
  assign regwrite_enable_out = regwrite_enable &
                               ~((op & illegal_c) | ((state_q == RESP) & timed_out_q));

endmodule
